// File: rtl/j1_uart_io.sv
// rtl/j1_uart_io.sv - memory-mapped 8N1 UART responder on the J1 I/O bus
//
// Ports:
//   sys_clk_i, sys_rst_i   clock, asynchronous active-low reset
//   io_rd, io_wr           one-cycle CPU read / write strobes
//   io_addr, io_dout       CPU byte address and write data
//   io_din                 combinational read data, 0 when not selected
//   int_req                registered level interrupt
//   uart_txd_o, uart_rxd_i serial line out (idle high) / in (asynchronous)
//
// Register map (index = io_addr[3:1]):
//   0 TXDATA (W)  1 RXDATA (R)  2 STATUS (R/W1C)  3 CTRL (RW)  4 DIV (RW)

module j1_uart_io #(
    parameter logic [15:0] BASE_ADDR = 16'h4000,
    parameter logic [15:0] DIV_RESET = 16'd216,
    parameter int          TX_DEPTH  = 8
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        int_req,
    output logic        uart_txd_o,
    input  logic        uart_rxd_i
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] DIV_MIN = 16'd15;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- register decode ----------------
    logic       sel;
    logic [2:0] idx;
    logic       wr_tx, rd_rx, wr_status, wr_ctrl, wr_div;
    logic       unused_addr0;

    assign sel          = (io_addr[15:4] == BASE_ADDR[15:4]);
    assign idx          = io_addr[3:1];
    assign unused_addr0 = io_addr[0];
    assign wr_tx        = io_wr & sel & (idx == 3'd0);
    assign rd_rx        = io_rd & sel & (idx == 3'd1);
    assign wr_status    = io_wr & sel & (idx == 3'd2);
    assign wr_ctrl      = io_wr & sel & (idx == 3'd3);
    assign wr_div       = io_wr & sel & (idx == 3'd4);

    logic [15:0] div_reg;
    logic [1:0]  ctrl;
    logic        rx_valid, rxovr, txovf, ferr;
    logic [7:0]  rx_byte;

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] tx_count;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    // Fullness is the registered count, so a write while full is dropped even if a pop happens that cycle.
    assign tx_full  = (tx_count == CW'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_push  = wr_tx & ~tx_full;

    always_ff @(posedge sys_clk_i) begin
        if (tx_push) fifo_mem[wr_ptr] <= io_dout[7:0];
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ---------------- TX serializer ----------------
    tx_state_t   tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [8:0]  tx_frame;     // remaining data bits then the stop bit, shifted out LSB first
    logic        tx_reload, tx_done, tx_idle;

    assign tx_done = (tx_cnt == '0);
    assign tx_idle = tx_empty & (tx_state == TX_IDLE);

    always_comb begin
        tx_next   = tx_state;
        tx_pop    = 1'b0;
        tx_reload = 1'b0;
        case (tx_state)
            TX_IDLE: if (!tx_empty) begin
                tx_pop = 1'b1; tx_reload = 1'b1; tx_next = TX_START;
            end
            TX_START: if (tx_done) begin
                tx_reload = 1'b1; tx_next = TX_DATA;
            end
            TX_DATA: if (tx_done) begin
                tx_reload = 1'b1;
                if (tx_bit == 3'd7) tx_next = TX_STOP;
            end
            TX_STOP: if (tx_done) begin
                if (!tx_empty) begin
                    tx_pop = 1'b1; tx_reload = 1'b1; tx_next = TX_START;
                end else begin
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_frame   <= '1;
            uart_txd_o <= 1'b1;
        end else begin
            tx_state <= tx_next;
            // The divisor is only picked up on reload, so a bit in flight finishes with the old value.
            if (tx_reload)     tx_cnt <= div_reg;
            else if (!tx_done) tx_cnt <= tx_cnt - 1'b1;
            if (tx_state == TX_DATA && tx_done) tx_bit <= tx_bit + 1'b1;
            if (tx_pop) begin
                tx_frame   <= {1'b1, fifo_mem[rd_ptr]};
                uart_txd_o <= 1'b0;
            end else if (tx_state != TX_IDLE && tx_done) begin
                uart_txd_o <= tx_frame[0];
                tx_frame   <= {1'b1, tx_frame[8:1]};
            end
        end
    end

    // ---------------- RX deserializer ----------------
    rx_state_t   rx_state, rx_next;
    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] rx_cnt, rx_half;
    logic [16:0] div_p1;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_sample, rx_load_half, rx_reload, rx_shift_en, rx_load;

    assign div_p1    = {1'b0, div_reg} + 17'd1;
    assign rx_half   = 16'(div_p1 >> 1);
    assign rx_sample = (rx_cnt == '0);

    always_comb begin
        rx_next      = rx_state;
        rx_load_half = 1'b0;
        rx_reload    = 1'b0;
        rx_shift_en  = 1'b0;
        rx_load      = 1'b0;
        case (rx_state)
            RX_IDLE: if (rx_prev & ~rx_s2) begin
                rx_load_half = 1'b1; rx_next = RX_START;
            end
            RX_START: if (rx_sample) begin
                if (rx_s2) rx_next = RX_IDLE;     // false start
                else begin
                    rx_reload = 1'b1; rx_next = RX_DATA;
                end
            end
            RX_DATA: if (rx_sample) begin
                rx_reload = 1'b1; rx_shift_en = 1'b1;
                if (rx_bit == 3'd7) rx_next = RX_STOP;
            end
            RX_STOP: if (rx_sample) begin
                rx_load = 1'b1; rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= uart_rxd_i;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            if (rx_load_half)    rx_cnt <= rx_half - 16'd1;
            else if (rx_reload)  rx_cnt <= div_reg;
            else if (!rx_sample) rx_cnt <= rx_cnt - 1'b1;
            if (rx_shift_en) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

    // ---------------- flags, control, interrupt ----------------
    // Set events take priority over read-clear and write-one-to-clear.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            rx_valid <= 1'b0;
            rx_byte  <= '0;
            rxovr    <= 1'b0;
            ferr     <= 1'b0;
            txovf    <= 1'b0;
            ctrl     <= '0;
            div_reg  <= DIV_RESET;
            int_req  <= 1'b0;
        end else begin
            if (rx_load)    rx_valid <= 1'b1;
            else if (rd_rx) rx_valid <= 1'b0;
            if (rx_load) rx_byte <= rx_shift;
            if (rx_load & rx_valid & ~rd_rx)   rxovr <= 1'b1;
            else if (wr_status & io_dout[3])   rxovr <= 1'b0;
            if (wr_tx & tx_full)               txovf <= 1'b1;
            else if (wr_status & io_dout[4])   txovf <= 1'b0;
            if (rx_load & ~rx_s2)              ferr  <= 1'b1;
            else if (wr_status & io_dout[5])   ferr  <= 1'b0;
            if (wr_ctrl) ctrl <= io_dout[1:0];
            if (wr_div)  div_reg <= (io_dout < DIV_MIN) ? DIV_MIN : io_dout;
            int_req <= (ctrl[0] & rx_valid) | (ctrl[1] & tx_idle);
        end
    end

    always_comb begin
        io_din = '0;
        if (sel) begin
            case (idx)
                3'd1:    io_din = {8'h00, rx_byte};
                3'd2:    io_din = {8'(tx_count), 2'b00, ferr, txovf, rxovr, rx_valid, tx_idle, tx_full};
                3'd3:    io_din = {14'd0, ctrl};
                3'd4:    io_din = div_reg;
                default: io_din = '0;
            endcase
        end
    end

endmodule

// File: doc/j1_uart_io.md
# j1_uart_io

Memory-mapped UART responder on the J1 I/O bus. It decodes CPU I/O reads and writes in the I/O space (`io_addr[15:14] != 0`) and provides:

- an 8-deep transmit FIFO feeding an 8N1 serializer;
- a single-byte receive holding register fed by an 8N1 deserializer;
- status, control and baud-divisor registers;
- a level interrupt request to the CPU `int_req` input.

## Interface
- `BASE_ADDR`, default 16'h4000: byte base address of the register window. Bits [3:0] must be 0.
- `DIV_RESET`, default 16'd216: reset value of the baud divisor. Bit period is DIV+1 clocks.
- `TX_DEPTH`, default 8: TX FIFO depth. Must be a power of 2, ≥ 2.
- `sys_clk_i`, in, 1: the single clock. Everything is on the rising edge.
- `sys_rst_i`, in, 1: reset, asynchronous and active-low (asserted at 0).
- `io_rd`, in, 1: CPU read strobe. One-cycle pulse.
- `io_wr`, in, 1: CPU write strobe. One-cycle pulse.
- `io_addr`, in, 16: CPU byte address, valid during the strobe.
- `io_dout`, in, 16: CPU write data.
- `io_din`, out, 16: read data, combinational from `io_addr`. It is 0 when the address is not selected, so outputs can be OR-ed with other responders.
- `int_req`, out, 1: registered level interrupt.
- `uart_txd_o`, out, 1: serial output. Idle high.
- `uart_rxd_i`, in, 1: serial input. Asynchronous.

## Operation
- **Select:** `sel = (io_addr[15:4] == BASE_ADDR[15:4])`. Register index is `io_addr[3:1]`; `io_addr[0]` is ignored.
- **Idx 0, TXDATA (W):** pushes `io_dout[7:0]` if the FIFO is not full. If full, the byte is dropped and sticky TXOVF is set. Reads return 0.
- **Idx 1, RXDATA (R):** returns `{8'h00, rx_byte}`. An `io_rd` with `rx_valid` set clears `rx_valid`.
- **Idx 2, STATUS (R / W1C):** read value is:
  - bit0 TXFULL;
  - bit1 TXIDLE (FIFO empty and serializer idle);
  - bit2 RXVALID;
  - bit3 RXOVR;
  - bit4 TXOVF;
  - bit5 FERR;
  - bits[15:8] FIFO count.
  - Writing 1 to bits 3/4/5 clears them.
- **Idx 3, CTRL (RW):** bit0 RXIE, bit1 TXIE. Other bits read 0.
- **Idx 4, DIV (RW):** 16-bit divisor. Written values below 15 are stored as 15.
- **Idx 5–7:** reads return 0; writes are ignored.
- **TX FSM:** TX_IDLE → TX_START → TX_DATA(×8, LSB first) → TX_STOP → TX_IDLE. Each state lasts DIV+1 clocks.
  - It leaves TX_IDLE when the FIFO is non-empty, popping the head in the same cycle.
  - From TX_STOP it goes directly to TX_START if the FIFO is non-empty, giving back-to-back frames with no idle gap.
- **RX path:** `uart_rxd_i` passes through a 2-flop synchronizer.
- **RX FSM:** RX_IDLE → RX_START → RX_DATA(×8) → RX_STOP.
  - A falling edge in RX_IDLE starts the count. The start bit is sampled at (DIV+1)>>1 clocks; if it is high, this is a false start and the FSM returns to RX_IDLE.
  - Data and stop bits are sampled every DIV+1 clocks after the start-bit sample.
  - At the stop sample the byte always loads into `rx_byte` and `rx_valid` is set. A low stop bit also sets FERR. If `rx_valid` was already 1, RXOVR is set and the new byte overwrites the old one.
  - The FSM returns to RX_IDLE immediately after the stop sample.
- **Interrupt:** `int_req` is registered from `(RXIE & rx_valid) | (TXIE & TXIDLE)`.
- **Simultaneous events:**
  - An RXDATA read in the same cycle as a byte load: the new byte wins, `rx_valid` stays 1, RXOVR is not set.
  - A TXDATA write while full in the same cycle as a pop: the write is dropped, because fullness is the registered state.
  - A W1C in the same cycle as a set event: the set wins.
- **Divisor change mid-frame:** a DIV write takes effect at the next bit-counter reload. The current bit completes with the old value.

## Timing
- **Reset values:**
  - `uart_txd_o`=1, `int_req`=0, FIFO empty, both FSMs idle;
  - all flags 0, CTRL=0, DIV=DIV_RESET;
  - `io_din`=0 for any unselected address.
- **Register reads:** zero latency. `io_din` is valid in the same cycle as `io_addr`, because the CPU samples it in the strobe cycle. Read side effects (RXVALID clear) take effect at the clock edge ending the `io_rd` cycle.
- **TX write-to-line latency:** a TXDATA write at edge n shows count+1 after edge n. If TX is idle, the pop and transition to TX_START occur at edge n+1, and `uart_txd_o` falls after edge n+1, i.e. 2 clocks after the write strobe.
- **Frame length:** 10×(DIV+1) clocks.
- **RX completion:** `rx_valid` rises at the edge after the stop sample, 2 synchronizer clocks plus 9.5 bit times after the line falls.
- **Interrupt latency:** `int_req` lags its source flags by 1 clock.

## Test plan
- **Reset and basic TX:**
  - Stimulus: reset low 3 cycles; DIV=15; write 0x55 to 0x4000.
  - Required: `txd` low 2 clocks after the strobe; bit pattern 0,1,0,1,0,1,0,1,0,1 each 16 clocks; STATUS.TXIDLE=1 at frame end (160 clocks).
- **FIFO full and overflow:**
  - Stimulus: DIV=15; write 10 bytes 0x01..0x0A in consecutive cycles.
  - Required: the first byte pops, FIFO holds 8 with TXFULL=1, byte 0x0A is dropped and TXOVF=1; the 9 accepted bytes go out back-to-back in 1440 clocks; a W1C of 0x0010 clears TXOVF.
- **RX receive and interrupt:**
  - Stimulus: CTRL=1; drive 0xA3 at 16 clocks/bit.
  - Required: RXVALID=1 and `int_req`=1 one clock later; a RXDATA read returns 0x00A3; `int_req` drops 1 clock after the read.
- **RX overrun, frame error and false start:**
  - Stimulus: send 0x11 then 0x22 without reading; then a frame with stop bit 0; then a 4-clock low glitch.
  - Required: RXOVR=1 and RXDATA=0x0022; FERR=1 on the bad frame; the glitch produces no byte.
- **Simultaneous read and load:**
  - Stimulus: RXDATA read in the exact cycle the second byte loads.
  - Required: `rx_valid` stays 1, RXOVR stays 0, the next read returns the second byte.
- **Address decode and reset mid-frame:**
  - Stimulus: read 0x4010 and 0x0002; then assert reset mid-TX.
  - Required: `io_din`=0 for both reads; after reset `txd` is immediately 1, count=0, DIV=216.
